// File: rtl/output_update_ctrl.sv
// Output-layer weight/bias update sequencer.
// Scans a latched per-neuron error-sign vector. For every neuron with a
// clean (non-conflicting) error sign it issues one start pulse to the
// delta_weight2/delta_bias2 datapath, streams the hidden index 0..NHIDDEN-1,
// and produces the one-cycle-delayed weight/bias write-back strobes.
module output_update_ctrl #(
   parameter int NOUT       = 10,
   parameter int NHIDDEN    = 256,
   parameter int COUNT_BIT2 = 8,
   parameter int OBITS      = 4
) (
   input  logic                  clk,
   input  logic                  reset_b,
   input  logic                  err_valid,
   input  logic [NOUT-1:0]       err_pos,
   input  logic [NOUT-1:0]       err_neg,
   output logic                  busy,
   output logic                  done,
   output logic                  start_pos,
   output logic                  start_neg,
   output logic [COUNT_BIT2-1:0] hid_addr,
   output logic                  hid_rd_en,
   output logic [OBITS-1:0]      w_neuron,
   output logic [COUNT_BIT2-1:0] w_addr,
   output logic                  w_we,
   output logic                  b_we
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      STREAM = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   localparam logic [OBITS-1:0]      LAST_N = OBITS'(NOUT - 1);
   localparam logic [COUNT_BIT2-1:0] LAST_K = COUNT_BIT2'(NHIDDEN - 1);

   state_t          state;
   logic [NOUT-1:0] pmask;
   logic [NOUT-1:0] nmask;
   logic [OBITS-1:0] n;

   // Pass sequencer: mask latch, neuron scan and hidden-index stream.
   // hid_addr doubles as the stream counter k; it is returned to 0 on stream exit.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state     <= IDLE;
         pmask     <= '0;
         nmask     <= '0;
         n         <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         start_pos <= 1'b0;
         start_neg <= 1'b0;
         hid_rd_en <= 1'b0;
         hid_addr  <= '0;
      end else begin
         start_pos <= 1'b0;
         start_neg <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (err_valid) begin
                  pmask <= err_pos & ~err_neg;
                  nmask <= err_neg & ~err_pos;
                  n     <= '0;
                  busy  <= 1'b1;
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (pmask[n] | nmask[n]) begin
                  state     <= STREAM;
                  hid_rd_en <= 1'b1;
                  hid_addr  <= '0;
                  start_pos <= pmask[n];
                  start_neg <= nmask[n];
               end else if (n == LAST_N) begin
                  state <= DRAIN;
               end else begin
                  n <= n + 1'b1;
               end
            end
            STREAM: begin
               if (hid_addr == LAST_K) begin
                  hid_rd_en <= 1'b0;
                  hid_addr  <= '0;
                  if (n == LAST_N) begin
                     state <= DRAIN;
                  end else begin
                     n     <= n + 1'b1;
                     state <= SCAN;
                  end
               end else begin
                  hid_addr <= hid_addr + 1'b1;
               end
            end
            DRAIN: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Write-back strobes and addresses trail the read stream by one cycle,
   // matching the registered datapath output.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         w_we     <= 1'b0;
         b_we     <= 1'b0;
         w_addr   <= '0;
         w_neuron <= '0;
      end else begin
         w_we     <= hid_rd_en;
         b_we     <= start_pos | start_neg;
         w_addr   <= hid_addr;
         w_neuron <= n;
      end
   end

endmodule

// File: tb/tb_output_update_ctrl.sv
// Self-checking bench for output_update_ctrl: table of passes plus random
// masks, each checked cycle by cycle against a schedule model, plus a
// hand-written mid-pass reset sequence.
module tb_output_update_ctrl;

   localparam int NOUT       = 10;
   localparam int NHIDDEN    = 256;
   localparam int COUNT_BIT2 = 8;
   localparam int OBITS      = 4;

   logic                  clk;
   logic                  reset_b;
   logic                  err_valid;
   logic [NOUT-1:0]       err_pos;
   logic [NOUT-1:0]       err_neg;
   logic                  busy;
   logic                  done;
   logic                  start_pos;
   logic                  start_neg;
   logic [COUNT_BIT2-1:0] hid_addr;
   logic                  hid_rd_en;
   logic [OBITS-1:0]      w_neuron;
   logic [COUNT_BIT2-1:0] w_addr;
   logic                  w_we;
   logic                  b_we;

   output_update_ctrl #(
      .NOUT      (NOUT),
      .NHIDDEN   (NHIDDEN),
      .COUNT_BIT2(COUNT_BIT2),
      .OBITS     (OBITS)
   ) dut (
      .clk      (clk),
      .reset_b  (reset_b),
      .err_valid(err_valid),
      .err_pos  (err_pos),
      .err_neg  (err_neg),
      .busy     (busy),
      .done     (done),
      .start_pos(start_pos),
      .start_neg(start_neg),
      .hid_addr (hid_addr),
      .hid_rd_en(hid_rd_en),
      .w_neuron (w_neuron),
      .w_addr   (w_addr),
      .w_we     (w_we),
      .b_we     (b_we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors;
   int miscompares;

   // Expected per-cycle behaviour of one pass.
   typedef struct {
      logic busy;
      logic done;
      logic sp;
      logic sn;
      logic rd;
      int   addr;
      int   n;
   } cyc_t;

   typedef struct {
      logic [NOUT-1:0] pos;
      logic [NOUT-1:0] neg;
      int              inject;
   } vec_t;

   cyc_t model[$];
   vec_t tbl[$];

   task automatic chk(input string name, input int cyc, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Build the expected cycle schedule from the masks: one scan cycle per
   // neuron, NHIDDEN stream cycles for each active one, one drain cycle,
   // then the done cycle and a quiet idle cycle.
   task automatic build_model(input logic [NOUT-1:0] pos, input logic [NOUT-1:0] neg);
      logic [NOUT-1:0] pm;
      logic [NOUT-1:0] nm;
      cyc_t c;
      pm = pos & ~neg;
      nm = neg & ~pos;
      model.delete();
      for (int i = 0; i < NOUT; i++) begin
         c = '{busy: 1'b1, done: 1'b0, sp: 1'b0, sn: 1'b0, rd: 1'b0, addr: 0, n: i};
         model.push_back(c);
         if (pm[i] | nm[i]) begin
            for (int k = 0; k < NHIDDEN; k++) begin
               c = '{busy: 1'b1, done: 1'b0, sp: (k == 0) && pm[i], sn: (k == 0) && nm[i],
                     rd: 1'b1, addr: k, n: i};
               model.push_back(c);
            end
         end
      end
      c = '{busy: 1'b1, done: 1'b0, sp: 1'b0, sn: 1'b0, rd: 1'b0, addr: 0, n: NOUT - 1};
      model.push_back(c);
      c = '{busy: 1'b0, done: 1'b1, sp: 1'b0, sn: 1'b0, rd: 1'b0, addr: 0, n: NOUT - 1};
      model.push_back(c);
      c = '{busy: 1'b0, done: 1'b0, sp: 1'b0, sn: 1'b0, rd: 1'b0, addr: 0, n: NOUT - 1};
      model.push_back(c);
   endtask

   // Apply one pass and compare every cycle. Entered and left at posedge+1.
   // inject >= 0 pulses a conflicting err_valid at that cycle of the pass.
   task automatic run_pass(input logic [NOUT-1:0] pos, input logic [NOUT-1:0] neg,
                           input int inject);
      int   active;
      int   n_busy, n_start, n_wwe, n_bwe, n_done, last_start;
      cyc_t e;
      cyc_t p;
      active = 0;
      for (int i = 0; i < NOUT; i++) active += (pos[i] ^ neg[i]) ? 1 : 0;
      build_model(pos, neg);
      err_pos   = pos;
      err_neg   = neg;
      err_valid = 1'b1;
      @(posedge clk); #1;
      err_valid = 1'b0;
      n_busy = 0; n_start = 0; n_wwe = 0; n_bwe = 0; n_done = 0; last_start = -1;
      for (int c = 0; c < model.size(); c++) begin
         if (c == inject + 1) err_valid = 1'b0;
         e = model[c];
         if (c == 0) p = '{busy: 1'b0, done: 1'b0, sp: 1'b0, sn: 1'b0, rd: 1'b0, addr: 0, n: 0};
         else        p = model[c-1];
         chk("busy",      c, int'(busy),      int'(e.busy));
         chk("done",      c, int'(done),      int'(e.done));
         chk("start_pos", c, int'(start_pos), int'(e.sp));
         chk("start_neg", c, int'(start_neg), int'(e.sn));
         chk("hid_rd_en", c, int'(hid_rd_en), int'(e.rd));
         if (e.rd) chk("hid_addr", c, int'(hid_addr), e.addr);
         chk("w_we", c, int'(w_we), int'(p.rd));
         chk("b_we", c, int'(b_we), int'(p.sp | p.sn));
         if (p.rd) chk("w_addr", c, int'(w_addr), p.addr);
         if (p.rd | p.sp | p.sn) chk("w_neuron", c, int'(w_neuron), p.n);
         n_busy += int'(busy);
         n_wwe  += int'(w_we);
         n_bwe  += int'(b_we);
         n_done += int'(done);
         if (start_pos | start_neg) begin
            n_start++;
            if (last_start >= 0) chk("start_gap_ok", c, int'((c - last_start) >= NHIDDEN + 1), 1);
            last_start = c;
         end
         if (c == inject) begin
            err_valid = 1'b1;
            err_pos   = '1;
            err_neg   = '0;
         end
         @(posedge clk); #1;
      end
      err_valid = 1'b0;
      chk("busy_cycles", -1, n_busy, NOUT + NHIDDEN * active + 1);
      chk("start_count", -1, n_start, active);
      chk("w_we_count",  -1, n_wwe, NHIDDEN * active);
      chk("b_we_count",  -1, n_bwe, active);
      chk("done_count",  -1, n_done, 1);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_busy"},      -1, int'(busy),      0);
      chk({name, "_done"},      -1, int'(done),      0);
      chk({name, "_start_pos"}, -1, int'(start_pos), 0);
      chk({name, "_start_neg"}, -1, int'(start_neg), 0);
      chk({name, "_hid_rd_en"}, -1, int'(hid_rd_en), 0);
      chk({name, "_hid_addr"},  -1, int'(hid_addr),  0);
      chk({name, "_w_we"},      -1, int'(w_we),      0);
      chk({name, "_b_we"},      -1, int'(b_we),      0);
      chk({name, "_w_addr"},    -1, int'(w_addr),    0);
      chk({name, "_w_neuron"},  -1, int'(w_neuron),  0);
   endtask

   initial begin
      vec_t v;
      vectors     = 0;
      miscompares = 0;
      reset_b     = 1'b0;
      err_valid   = 1'b0;
      err_pos     = '0;
      err_neg     = '0;

      tbl.push_back('{pos: 10'h000, neg: 10'h000, inject: -1});
      tbl.push_back('{pos: 10'h004, neg: 10'h000, inject: -1});
      tbl.push_back('{pos: 10'h001, neg: 10'h200, inject: -1});
      tbl.push_back('{pos: 10'h010, neg: 10'h010, inject: -1});
      tbl.push_back('{pos: 10'h002, neg: 10'h000, inject: 150});
      for (int i = 0; i < 4; i++) begin
         v.pos    = NOUT'($urandom);
         v.neg    = NOUT'($urandom);
         v.inject = (i == 1) ? 40 : -1;
         tbl.push_back(v);
      end

      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      reset_b = 1'b1;
      @(posedge clk); #1;

      for (int t = 0; t < tbl.size(); t++) begin
         run_pass(tbl[t].pos, tbl[t].neg, tbl[t].inject);
         repeat (2) @(posedge clk);
         #1;
      end

      // Mid-pass reset at k=100 of neuron 3: scan 0..3 takes cycles 0..3,
      // so k=100 is cycle 104 after acceptance.
      err_pos   = 10'h008;
      err_neg   = 10'h000;
      err_valid = 1'b1;
      @(posedge clk); #1;
      err_valid = 1'b0;
      repeat (104) @(posedge clk);
      #1;
      chk("pre_reset_hid_addr",  104, int'(hid_addr),  100);
      chk("pre_reset_hid_rd_en", 104, int'(hid_rd_en), 1);
      chk("pre_reset_w_neuron",  104, int'(w_neuron),  3);
      reset_b = 1'b0;
      #1;
      chk_all_zero("abort");
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("abort_done", i, int'(done), 0);
         chk("abort_w_we", i, int'(w_we), 0);
      end
      @(negedge clk);
      reset_b = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("post_reset_done", i, int'(done), 0);
         chk("post_reset_busy", i, int'(busy), 0);
      end
      run_pass(10'h208, 10'h040, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
